// File: rtl/teclado_varredura.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces whole
// sweeps and emits one key code per physical press on a single-cycle key_valid.
module teclado_varredura #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] lin,
  output logic [3:0] col,
  output logic [3:0] s,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;
  typedef enum logic [1:0] {SW_NONE, SW_ONE, SW_MULTI} sweep_t;

  // Snapshot bit index is {column, row}; translate to the keypad legend.
  function automatic logic [3:0] key_code(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'h0: code = 4'd1;
      4'h1: code = 4'd4;
      4'h2: code = 4'd7;
      4'h3: code = 4'd10;
      4'h4: code = 4'd2;
      4'h5: code = 4'd5;
      4'h6: code = 4'd8;
      4'h7: code = 4'd0;
      4'h8: code = 4'd3;
      4'h9: code = 4'd6;
      4'hA: code = 4'd9;
      4'hB: code = 4'd11;
      4'hC: code = 4'd12;
      4'hD: code = 4'd13;
      4'hE: code = 4'd14;
      default: code = 4'd15;
    endcase
    return code;
  endfunction

  logic [3:0]       lin_meta, lin_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [15:0]      snapshot, snap_next;
  logic             tick, sweep_done;

  // NOTE: every clocked block uses non-blocking assignments so the two
  // synchroniser stages (and all other registers) update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lin_meta <= 4'hF;
      lin_sync <= 4'hF;
    end else begin
      lin_meta <= lin;
      lin_sync <= lin_meta;
    end
  end

  assign tick       = (div == DIV_LAST);
  assign sweep_done = tick && (col_idx == 2'd3);

  // The sweep is judged on the snapshot including the column sampled this tick.
  // NOTE: combinational blocks assign every output a default first, so no
  // path through them can leave a value held and infer a latch.
  always_comb begin
    snap_next = snapshot;
    snap_next[{col_idx, 2'b00} +: 4] = ~lin_sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div      <= '0;
      col_idx  <= 2'd0;
      col      <= 4'b1110;
      snapshot <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        snapshot <= snap_next;
        col_idx  <= col_idx + 2'd1;
        col      <= {col[2:0], col[3]};
      end
    end
  end

  logic [4:0] n_hits;
  logic [3:0] hit_idx;
  logic [3:0] hit_code;
  sweep_t     sweep_cls;

  always_comb begin
    n_hits  = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_next[i]) begin
        n_hits  = n_hits + 5'd1;
        hit_idx = 4'(i);
      end
    end
    if (n_hits == 5'd0)      sweep_cls = SW_NONE;
    else if (n_hits == 5'd1) sweep_cls = SW_ONE;
    else                     sweep_cls = SW_MULTI;
    hit_code = key_code(hit_idx);
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       cand, cand_n;
  logic             accept;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (sweep_done) begin
      case (state)
        IDLE: begin
          if (sweep_cls == SW_ONE) begin
            cand_n = hit_code;
            if (DEBOUNCE == 1) begin
              state_n = HELD;
              cnt_n   = '0;
              accept  = 1'b1;
            end else begin
              state_n = CONFIRM;
              cnt_n   = CNT_ONE;
            end
          end
        end
        CONFIRM: begin
          if (sweep_cls == SW_ONE) begin
            if (hit_code == cand) begin
              if (cnt_inc == CNT_MAX) begin
                state_n = HELD;
                cnt_n   = '0;
                accept  = 1'b1;
              end else begin
                cnt_n = cnt_inc;
              end
            end else begin
              cand_n = hit_code;
              cnt_n  = CNT_ONE;
            end
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        HELD: begin
          // Rolling onto another key keeps us here: one code per press.
          if (sweep_cls == SW_NONE) begin
            if (DEBOUNCE == 1) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              state_n = RELEASE;
              cnt_n   = CNT_ONE;
            end
          end
        end
        RELEASE: begin
          if (sweep_cls == SW_NONE) begin
            if (cnt_inc == CNT_MAX) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = HELD;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s         <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) s <= cand_n;
      key_held  <= (state_n == HELD) || (state_n == RELEASE);
    end
  end

endmodule

// File: tb/tb_teclado_varredura.sv
// Randomised self-checking bench for teclado_varredura: a keypad model drives lin
// from col, and a sweep-level run-length model predicts every accepted key.
module tb_teclado_varredura;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int SWEEP    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lin, col, s;
  logic       key_valid, key_held;
  logic [15:0] keys;  // pressed keys, bit 4*column + row

  int checks   = 0;
  int failures = 0;

  int row_codes [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

  // Reference model state: lengths of the current identical-sweep runs.
  int   one_run, none_run, run_key;
  bit   m_held;
  logic [3:0] m_s;

  always #5 clk = ~clk;

  teclado_varredura #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .lin(lin), .col(col), .s(s),
    .key_valid(key_valid), .key_held(key_held)
  );

  // A pressed key shorts its row to its column; only a driven-low column pulls.
  always_comb begin
    lin = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (col[c] === 1'b0 && keys[4*c+r]) lin[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] key_bit(input int code);
    logic [15:0] m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_codes[r][c] == code) m[4*c+r] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    one_run = 0; none_run = 0; run_key = 0; m_held = 0; m_s = 4'd0;
  endtask

  task automatic model_sweep(input logic [15:0] m, output bit accept);
    int n, k;
    n = $countones(m);
    k = 0;
    accept = 0;
    if (n == 0) begin
      none_run++;
      one_run = 0;
    end else if (n == 1) begin
      for (int b = 0; b < 16; b++) if (m[b]) k = row_codes[b % 4][b / 4];
      if (one_run > 0 && k == run_key) one_run++;
      else begin run_key = k; one_run = 1; end
      none_run = 0;
    end else begin
      one_run = 0;
      none_run = 0;
    end
    if (!m_held && one_run >= DEBOUNCE) begin
      m_held = 1; accept = 1; m_s = 4'(run_key);
    end else if (m_held && none_run >= DEBOUNCE) begin
      m_held = 0;
    end
  endtask

  // Called just after an evaluation edge or a reset release; runs one sweep.
  task automatic run_sweep(input logic [15:0] m);
    bit acc;
    int pulses;
    logic [3:0] exp_col;
    keys = m;
    pulses = 0;
    for (int k = 1; k <= SWEEP; k++) begin
      @(posedge clk);
      #1;
      if (k % SCAN_DIV == 0) begin
        exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
        check("col", col, exp_col);
      end
      if (k < SWEEP && key_valid) pulses++;
    end
    model_sweep(m, acc);
    check("key_valid", key_valid, acc);
    check("key_held", key_held, m_held);
    check("s", s, m_s);
    check("stray_pulse", pulses, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_col", col, 4'b1110);
    check("rst_s", s, 4'd0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [15:0] m, prev_single;
    int sel;
    keys = '0;
    model_clear();
    apply_reset();

    // Idle scanning: columns rotate, nothing accepted.
    repeat (2) run_sweep('0);

    // Steady '5', then release.
    repeat (4) run_sweep(key_bit(5));
    repeat (4) run_sweep('0);

    // '#' with bounce: on, off, on, on, on.
    run_sweep(key_bit(11));
    run_sweep('0);
    repeat (3) run_sweep(key_bit(11));
    repeat (3) run_sweep('0);

    // '1' and '2' together: ghost, never accepted.
    repeat (4) run_sweep(key_bit(1) | key_bit(2));
    repeat (2) run_sweep('0);

    // Roll from '7' to '8': no second code, then a fresh '8'.
    repeat (3) run_sweep(key_bit(7));
    run_sweep(key_bit(7) | key_bit(8));
    repeat (2) run_sweep(key_bit(8));
    repeat (3) run_sweep('0);
    repeat (3) run_sweep(key_bit(8));
    repeat (3) run_sweep('0);

    // Reset while holding 'A' (code 12): re-accepted after a fresh debounce.
    repeat (3) run_sweep(key_bit(12));
    apply_reset();
    repeat (4) run_sweep(key_bit(12));
    repeat (3) run_sweep('0);

    // Random presses, bounces, ghosts and releases.
    prev_single = key_bit(3);
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) m = '0;
      else if (sel <= 6) m = prev_single;
      else if (sel <= 8) begin
        m = 16'b1 << $urandom_range(0, 15);
        prev_single = m;
      end else m = (16'b1 << $urandom_range(0, 15)) | (16'b1 << $urandom_range(0, 15));
      if (i == 120) begin
        keys = m;
        apply_reset();
      end
      run_sweep(m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
